ext_unit_arbiter: RTL and testbench

- Shares one immediate-extension unit between two requesters: req0 (instruction decode) and req1 (branch-target calculation).
- Arbitrates round-robin, performs the selected extend/shift operation, and holds the 32-bit result in a single-entry output register with a valid/ready handshake toward the datapath consumer.
- Replaces per-requester extenders in the single-cycle CPU datapath.

---
 rtl/ext_unit_arbiter.sv | 115 +++++++++++
 tb/tb_ext_unit_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ext_unit_arbiter.sv
// rtl/ext_unit_arbiter.sv - round-robin shared immediate extender with single-entry result register
// Optional grant counters when EXT_ARB_STATS_EN is defined.
module ext_unit_arbiter #(
    parameter int IMM_W      = 16,
    parameter int OUT_W      = 32,
    parameter int RESET_PRIO = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_valid_i,
    input  logic [IMM_W-1:0] req0_imm_i,
    input  logic [1:0]       req0_mode_i,
    output logic             req0_ready_o,
    input  logic             req1_valid_i,
    input  logic [IMM_W-1:0] req1_imm_i,
    input  logic [1:0]       req1_mode_i,
    output logic             req1_ready_o,
    output logic             res_valid_o,
    output logic [OUT_W-1:0] res_data_o,
    output logic             res_id_o,
    input  logic             res_ready_i
`ifdef EXT_ARB_STATS_EN
    ,
    output logic [15:0]      grant0_cnt_o,
    output logic [15:0]      grant1_cnt_o
`endif
);

    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    state_t           r_state;
    logic             r_prio;
    logic [OUT_W-1:0] r_data;
    logic             r_id;

    logic             w_grant1;
    logic             w_can_accept;
    logic             w_acc0;
    logic             w_acc1;
    logic             w_accept;
    logic [IMM_W-1:0] w_sel_imm;
    logic [1:0]       w_sel_mode;
    logic [OUT_W-1:0] w_ext;

    function automatic logic [OUT_W-1:0] extend(input logic [IMM_W-1:0] imm, input logic [1:0] mode);
        logic [OUT_W-1:0] v;
        case (mode)
            2'b00:   v = {{(OUT_W-IMM_W){imm[IMM_W-1]}}, imm};
            2'b01:   v = {{(OUT_W-IMM_W){1'b0}}, imm};
            2'b10:   v = {imm, {(OUT_W-IMM_W){1'b0}}};
            default: v = {{(OUT_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
        endcase
        return v;
    endfunction

    // r_prio names the requester that wins when both are valid.
    assign w_grant1     = req1_valid_i & (~req0_valid_i | r_prio);
    assign w_can_accept = (r_state == ST_EMPTY) | res_ready_i;
    assign req0_ready_o = req0_valid_i & ~w_grant1 & w_can_accept;
    assign req1_ready_o = w_grant1 & w_can_accept;
    assign w_acc0       = req0_ready_o;
    assign w_acc1       = req1_ready_o;
    assign w_accept     = w_acc0 | w_acc1;
    assign w_sel_imm    = w_grant1 ? req1_imm_i  : req0_imm_i;
    assign w_sel_mode   = w_grant1 ? req1_mode_i : req0_mode_i;
    assign w_ext        = extend(w_sel_imm, w_sel_mode);

    assign res_valid_o  = (r_state == ST_FULL);
    assign res_data_o   = r_data;
    assign res_id_o     = r_id;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
            r_id    <= 1'b0;
            r_prio  <= (RESET_PRIO != 0);
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) r_state <= ST_FULL;
                end
                ST_FULL: begin
                    if (res_ready_i && !w_accept) r_state <= ST_EMPTY;
                end
                default: r_state <= ST_EMPTY;
            endcase
            // A drain and a load on the same edge keep the register full.
            if (w_accept) begin
                r_data <= w_ext;
                r_id   <= w_grant1;
                r_prio <= ~w_grant1;
            end
        end
    end

`ifdef EXT_ARB_STATS_EN
    logic [15:0] r_grant0_cnt;
    logic [15:0] r_grant1_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_grant0_cnt <= '0;
            r_grant1_cnt <= '0;
        end else begin
            if (w_acc0 && r_grant0_cnt != 16'hFFFF) r_grant0_cnt <= r_grant0_cnt + 16'd1;
            if (w_acc1 && r_grant1_cnt != 16'hFFFF) r_grant1_cnt <= r_grant1_cnt + 16'd1;
        end
    end

    assign grant0_cnt_o = r_grant0_cnt;
    assign grant1_cnt_o = r_grant1_cnt;
`endif

endmodule

// File: tb/tb_ext_unit_arbiter.sv
// tb/tb_ext_unit_arbiter.sv - self-checking bench for ext_unit_arbiter with a behavioural reference model
module tb_ext_unit_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req0_valid_i = 1'b0;
    logic [15:0] req0_imm_i = '0;
    logic [1:0]  req0_mode_i = '0;
    logic        req0_ready_o;
    logic        req1_valid_i = 1'b0;
    logic [15:0] req1_imm_i = '0;
    logic [1:0]  req1_mode_i = '0;
    logic        req1_ready_o;
    logic        res_valid_o;
    logic [31:0] res_data_o;
    logic        res_id_o;
    logic        res_ready_i = 1'b0;
`ifdef EXT_ARB_STATS_EN
    logic [15:0] grant0_cnt_o;
    logic [15:0] grant1_cnt_o;
`endif

    ext_unit_arbiter #(.IMM_W(16), .OUT_W(32), .RESET_PRIO(0)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_imm_i(req0_imm_i), .req0_mode_i(req0_mode_i), .req0_ready_o(req0_ready_o),
        .req1_valid_i(req1_valid_i), .req1_imm_i(req1_imm_i), .req1_mode_i(req1_mode_i), .req1_ready_o(req1_ready_o),
        .res_valid_o(res_valid_o), .res_data_o(res_data_o), .res_id_o(res_id_o), .res_ready_i(res_ready_i)
`ifdef EXT_ARB_STATS_EN
        , .grant0_cnt_o(grant0_cnt_o), .grant1_cnt_o(grant1_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the result register should hold and who has priority.
    bit          m_valid;
    logic [31:0] m_data;
    int          m_id;
    int          m_prio;
    bit          acc0, acc1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ext_ref(input logic [15:0] imm, input logic [1:0] md);
        int s;
        int u;
        s = int'($signed(imm));
        u = int'(imm);
        case (md)
            2'd0:    return 32'(s);
            2'd1:    return 32'(u);
            2'd2:    return 32'(u * 65536);
            default: return 32'(s * 4);
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_data  = '0;
        m_id    = 0;
        m_prio  = 0;
    endtask

    task automatic step(input bit v0, input logic [15:0] i0, input logic [1:0] md0,
                        input bit v1, input logic [15:0] i1, input logic [1:0] md1,
                        input bit rdy);
        int winner;
        bit room;
        req0_valid_i = v0; req0_imm_i = i0; req0_mode_i = md0;
        req1_valid_i = v1; req1_imm_i = i1; req1_mode_i = md1;
        res_ready_i  = rdy;
        #4;
        winner = -1;
        if (v0 && v1) winner = m_prio;
        else if (v0)  winner = 0;
        else if (v1)  winner = 1;
        room = !m_valid || rdy;
        acc0 = room && (winner == 0);
        acc1 = room && (winner == 1);
        chk("ready0", 32'(req0_ready_o), 32'(acc0));
        chk("ready1", 32'(req1_ready_o), 32'(acc1));
        chk("res_valid", 32'(res_valid_o), 32'(m_valid));
        chk("res_data", res_data_o, m_data);
        chk("res_id", 32'(res_id_o), 32'(m_id));
        if (acc0 || acc1) begin
            m_valid = 1;
            m_data  = acc0 ? ext_ref(i0, md0) : ext_ref(i1, md1);
            m_id    = winner;
            m_prio  = 1 - winner;
        end else if (rdy) begin
            m_valid = 0;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        req0_valid_i = 0; req1_valid_i = 0; res_ready_i = 0;
        rst_i = 0;
        #1;
        model_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1;
    endtask

    logic [31:0] mode_exp [4];
    int          rr_exp [4];

    initial begin
        bit v0, v1, rdy;
        logic [15:0] i0, i1;
        logic [1:0] md0, md1;

        model_reset();
        #2;
        chk("rst_valid", 32'(res_valid_o), 32'd0);
        chk("rst_data", res_data_o, 32'd0);
        chk("rst_id", 32'(res_id_o), 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1;

        step(1, 16'h8004, 2'b00, 0, 16'h0, 2'b00, 1);
        chk("sext_valid", 32'(res_valid_o), 32'd1);
        chk("sext_data", res_data_o, 32'hFFFF8004);
        chk("sext_id", 32'(res_id_o), 32'd0);

        mode_exp[0] = 32'h00008004; mode_exp[1] = 32'h80040000;
        mode_exp[2] = 32'hFFFE0010; mode_exp[3] = 32'h0000000C;
        for (int k = 0; k < 4; k++) begin
            step(1, (k == 3) ? 16'h0003 : 16'h8004, (k == 3) ? 2'b11 : 2'(k + 1), 0, 16'h0, 2'b00, 1);
            chk($sformatf("mode_data_%0d", k), res_data_o, mode_exp[k]);
        end

        do_reset();
        rr_exp[0] = 0; rr_exp[1] = 1; rr_exp[2] = 0; rr_exp[3] = 1;
        for (int k = 0; k < 4; k++) begin
            step(1, 16'h1000 + 16'(k), 2'b01, 1, 16'h2000 + 16'(k), 2'b01, 1);
            chk($sformatf("rr_id_%0d", k), 32'(res_id_o), 32'(rr_exp[k]));
            chk($sformatf("rr_valid_%0d", k), 32'(res_valid_o), 32'd1);
        end

        // Register holds req1's result; priority now with req0. Stall for five cycles.
        for (int k = 0; k < 5; k++) begin
            step(1, 16'h00AA, 2'b01, 1, 16'h00BB, 2'b01, 0);
            chk($sformatf("bp_hold_%0d", k), res_data_o, 32'h00002003);
        end
        step(1, 16'h00AA, 2'b01, 1, 16'h00BB, 2'b01, 1);
        chk("bp_release_id", 32'(res_id_o), 32'd0);
        chk("bp_release_data", res_data_o, 32'h000000AA);

        // Fill, leave req1 pending under backpressure, then reset asynchronously mid-cycle.
        step(0, 16'h0, 2'b00, 1, 16'h7777, 2'b01, 0);
        req0_valid_i = 0; req1_valid_i = 1; req1_imm_i = 16'h5555; res_ready_i = 0;
        #3;
        rst_i = 0;
        #1;
        chk("async_rst_valid", 32'(res_valid_o), 32'd0);
        chk("async_rst_data", res_data_o, 32'd0);
        model_reset();
        @(posedge clk_i); #1;
        rst_i = 1;
        step(1, 16'h0011, 2'b01, 1, 16'h0022, 2'b01, 1);
        chk("post_rst_grant", 32'(res_id_o), 32'd0);

`ifdef EXT_ARB_STATS_EN
        do_reset();
        for (int k = 0; k < 3; k++) step(1, 16'h0001, 2'b00, 0, 16'h0, 2'b00, 1);
        for (int k = 0; k < 2; k++) step(0, 16'h0, 2'b00, 1, 16'h0002, 2'b00, 1);
        chk("cnt0", 32'(grant0_cnt_o), 32'd3);
        chk("cnt1", 32'(grant1_cnt_o), 32'd2);
        force dut.r_grant0_cnt = 16'hFFFF;
        #1;
        release dut.r_grant0_cnt;
        step(1, 16'h0001, 2'b00, 0, 16'h0, 2'b00, 1);
        chk("cnt0_sat", 32'(grant0_cnt_o), 32'h0000FFFF);
`endif

        do_reset();
        acc0 = 1; acc1 = 1;
        v0 = 0; v1 = 0; i0 = '0; i1 = '0; md0 = '0; md1 = '0;
        for (int n = 0; n < 400; n++) begin
            if (!v0 || acc0) begin
                v0 = ($urandom_range(0, 3) != 0);
                i0 = 16'($urandom);
                md0 = 2'($urandom);
            end
            if (!v1 || acc1) begin
                v1 = ($urandom_range(0, 3) != 0);
                i1 = 16'($urandom);
                md1 = 2'($urandom);
            end
            rdy = ($urandom_range(0, 2) != 0);
            step(v0, i0, md0, v1, i1, md1, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
